// File: rtl/fbwriter_mc.sv
// fbwriter_mc: round-robin drain of NUM_CH FWFT pixel FIFOs into single-beat PLB master writes.
// Define FBWRITER_RETRY_EN to re-issue a failed write up to MAX_RETRY times before dropping it.
module fbwriter_mc #(
  parameter int          NUM_CH    = 2,
  parameter int          ADDR_W    = 30,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          MAX_RETRY = 3
) (
  input  logic                           PLB_clk,
  input  logic                           reset_n,
  input  logic [NUM_CH*(ADDR_W+32)-1:0]  fifo_data,
  input  logic [NUM_CH-1:0]              fifo_empty,
  output logic [NUM_CH-1:0]              fifo_rd_en,
  output logic                           IP2Bus_MstWr_Req,
  output logic                           IP2Bus_MstRd_Req,
  output logic                           IP2Bus_Mst_Lock,
  output logic                           IP2Bus_Mst_Reset,
  output logic [31:0]                    IP2Bus_Mst_Addr,
  output logic [3:0]                     IP2Bus_Mst_BE,
  output logic [31:0]                    IP2Bus_MstWr_d,
  input  logic                           Bus2IP_Mst_CmdAck,
  input  logic                           Bus2IP_Mst_Cmplt,
  input  logic                           Bus2IP_Mst_Error,
  input  logic                           Bus2IP_Mst_Cmd_Timeout,
  input  logic                           Bus2IP_MstWr_dst_rdy_n,
  output logic                           busy,
  output logic [15:0]                    err_count
);
  localparam int DW   = ADDR_W + 32;
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT} state_t;

  state_t          r_state, w_next;
  logic [1:0]      r_rst_sync;
  logic            w_rst_n;
  logic [CH_W-1:0] r_rr_ptr, w_gnt, w_idx;
  logic            w_found, w_grant, w_ok, w_fail, w_drop;
  logic [DW-1:0]   w_sel;
  logic [31:0]     r_addr, r_pix;
  logic [3:0]      r_be;
  logic [15:0]     r_err_cnt;
  logic            w_unused_rdy;

  // Assertion is immediate through the flop clears; release reaches the FSM two edges later.
  always_ff @(posedge PLB_clk or negedge reset_n) begin
    if (!reset_n) r_rst_sync <= 2'b00;
    else          r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  always_comb begin
    w_found = 1'b0;
    w_gnt   = '0;
    w_idx   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_idx = CH_W'((int'(r_rr_ptr) + i) % NUM_CH);
      if (!w_found && !fifo_empty[w_idx]) begin
        w_found = 1'b1;
        w_gnt   = w_idx;
      end
    end
  end

  assign w_grant = (r_state == S_IDLE) && w_rst_n && w_found;
  assign w_sel   = fifo_data[(NUM_CH - 1 - int'(w_gnt)) * DW +: DW];
  assign w_ok    = Bus2IP_Mst_Cmplt & ~Bus2IP_Mst_Error & ~Bus2IP_Mst_Cmd_Timeout;
  assign w_fail  = (Bus2IP_Mst_Cmplt & Bus2IP_Mst_Error) | Bus2IP_Mst_Cmd_Timeout;

  always_comb begin
    fifo_rd_en = '0;
    if (w_grant) fifo_rd_en[w_gnt] = 1'b1;
  end

`ifdef FBWRITER_RETRY_EN
  logic [7:0] r_retry;

  always_ff @(posedge PLB_clk or negedge w_rst_n) begin
    if (!w_rst_n)                                    r_retry <= '0;
    else if (w_grant)                                r_retry <= '0;
    else if (r_state != S_IDLE && w_fail && !w_drop) r_retry <= r_retry + 8'd1;
  end
`endif

  always_comb begin
    w_next = r_state;
    w_drop = 1'b0;
    case (r_state)
      S_IDLE: if (w_grant) w_next = S_REQ;
      S_REQ, S_WAIT: begin
        if (w_fail) begin
`ifdef FBWRITER_RETRY_EN
          if (int'(r_retry) < MAX_RETRY) begin
            w_next = S_REQ;
          end else begin
            w_next = S_IDLE;
            w_drop = 1'b1;
          end
`else
          w_next = S_IDLE;
          w_drop = 1'b1;
`endif
        end else if (w_ok) begin
          w_next = S_IDLE;
        end else if (r_state == S_REQ && Bus2IP_Mst_CmdAck) begin
          w_next = S_WAIT;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge PLB_clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_state   <= S_IDLE;
      r_rr_ptr  <= '0;
      r_addr    <= '0;
      r_pix     <= '0;
      r_be      <= '0;
      r_err_cnt <= '0;
    end else begin
      r_state <= w_next;
      if (w_grant) begin
        r_rr_ptr <= (int'(w_gnt) == NUM_CH - 1) ? '0 : w_gnt + 1'b1;
        r_addr   <= BASE_ADDR + (32'(w_sel[DW-1:32]) << 2);
        r_pix    <= w_sel[31:0];
        r_be     <= 4'hF;
      end
      if (w_drop && r_err_cnt != 16'hFFFF) r_err_cnt <= r_err_cnt + 16'd1;
    end
  end

  // Single-beat writes keep data valid for the whole transfer, so dst_rdy_n carries no information.
  assign w_unused_rdy     = Bus2IP_MstWr_dst_rdy_n;
  assign IP2Bus_MstWr_Req = (r_state == S_REQ);
  assign IP2Bus_MstRd_Req = 1'b0;
  assign IP2Bus_Mst_Lock  = 1'b0;
  assign IP2Bus_Mst_Reset = 1'b0;
  assign IP2Bus_Mst_Addr  = r_addr;
  assign IP2Bus_Mst_BE    = r_be;
  assign IP2Bus_MstWr_d   = r_pix;
  assign busy             = (r_state != S_IDLE);
  assign err_count        = r_err_cnt;
endmodule
